// File: rtl/ctrl_pipe_stager_pkg.sv
// ctrl_pipe_stager_pkg: shared types for the control-bundle stager.
//   ex_ctrl_t  - full control bundle carried into EX (all-zero = bubble)
//   mem_ctrl_t - subset of controls still needed in MEM
//   wb_ctrl_t  - subset of controls still needed in WB
//   fwd_sel_e  - operand forwarding select for the EX ALU muxes
package ctrl_pipe_stager_pkg;

    localparam int REG_ADDR_W_DEF = 5;

    typedef struct packed {
        logic       alu_src;
        logic       mem2reg;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic [1:0] aluop;
        logic       branch;
        logic       jalr_mode;
        logic       jal_mode;
    } ex_ctrl_t;

    typedef struct packed {
        logic mem_read;
        logic mem_write;
        logic mem2reg;
        logic reg_write;
    } mem_ctrl_t;

    typedef struct packed {
        logic mem2reg;
        logic reg_write;
    } wb_ctrl_t;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_e;

endpackage

// File: rtl/ctrl_fwd_unit.sv
// ctrl_fwd_unit: operand forwarding selects for both EX ALU operands.
//   ex_rs1_i/ex_rs2_i  - source registers of the instruction in EX
//   mem_reg_write_i, mem_rd_i - producer in MEM
//   wb_reg_write_i, wb_rd_i   - producer in WB (write enable already
//                               suppressed for rd == x0)
//   forward_a_o/forward_b_o   - FWD_MEM / FWD_WB / FWD_RF
module ctrl_fwd_unit
    import ctrl_pipe_stager_pkg::*;
#(
    parameter int REG_ADDR_W = REG_ADDR_W_DEF
) (
    input  logic [REG_ADDR_W-1:0] ex_rs1_i,
    input  logic [REG_ADDR_W-1:0] ex_rs2_i,
    input  logic                  mem_reg_write_i,
    input  logic [REG_ADDR_W-1:0] mem_rd_i,
    input  logic                  wb_reg_write_i,
    input  logic [REG_ADDR_W-1:0] wb_rd_i,
    output fwd_sel_e              forward_a_o,
    output fwd_sel_e              forward_b_o
);

    // MEM is the younger producer, so it is checked first.
    function automatic fwd_sel_e pick(input logic [REG_ADDR_W-1:0] rs);
        if (mem_reg_write_i && (mem_rd_i != '0) && (mem_rd_i == rs))
            return FWD_MEM;
        else if (wb_reg_write_i && (wb_rd_i == rs))
            return FWD_WB;
        else
            return FWD_RF;
    endfunction

    assign forward_a_o = pick(ex_rs1_i);
    assign forward_b_o = pick(ex_rs2_i);

endmodule

// File: rtl/ctrl_pipe_stager.sv
// ctrl_pipe_stager: carries decoder control through EX/MEM/WB stage
// registers, detects load-use stalls and EX redirects, and produces
// EX operand forwarding selects.
//   clk, reset           - rising-edge clock, synchronous active-high reset
//   id_*                 - ID-stage control fields and register indices
//   ex_redirect          - taken branch / resolved jump in EX (flush)
//   ex_ctrl, ex_rd       - EX bundle {ctrl[9:0], 2'b0}
//   mem_*, wb_*          - MEM and WB controls and destinations
//   forward_a/forward_b  - 00 regfile, 10 MEM, 01 WB
//   pc_write, ifid_write, ifid_flush - fetch-side control
// Optional: define CTRL_PERF_CNT_EN to add the CNT_W parameter and the
// stall_cnt / flush_cnt performance counter outputs.
module ctrl_pipe_stager
    import ctrl_pipe_stager_pkg::*;
#(
    parameter int REG_ADDR_W = REG_ADDR_W_DEF
`ifdef CTRL_PERF_CNT_EN
    , parameter int CNT_W = 32
`endif
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  id_alu_src,
    input  logic                  id_mem2reg,
    input  logic                  id_reg_write,
    input  logic                  id_mem_read,
    input  logic                  id_mem_write,
    input  logic                  id_branch,
    input  logic                  id_jalr_mode,
    input  logic                  id_jal_mode,
    input  logic [1:0]            id_aluop,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  id_uses_rs1,
    input  logic                  id_uses_rs2,
    input  logic                  ex_redirect,
    output logic [11:0]           ex_ctrl,
    output logic [REG_ADDR_W-1:0] ex_rd,
    output logic                  mem_mem_read,
    output logic                  mem_mem_write,
    output logic                  mem_mem2reg,
    output logic                  mem_reg_write,
    output logic [REG_ADDR_W-1:0] mem_rd,
    output logic                  wb_mem2reg,
    output logic                  wb_reg_write,
    output logic [REG_ADDR_W-1:0] wb_rd,
    output logic [1:0]            forward_a,
    output logic [1:0]            forward_b,
    output logic                  pc_write,
    output logic                  ifid_write,
    output logic                  ifid_flush
`ifdef CTRL_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]      stall_cnt,
    output logic [CNT_W-1:0]      flush_cnt
`endif
);

    ex_ctrl_t                ex_q, ex_d, id_bundle;
    logic [REG_ADDR_W-1:0]   ex_rd_q, ex_rd_d, ex_rs1_q, ex_rs1_d, ex_rs2_q, ex_rs2_d;
    mem_ctrl_t               mem_q;
    logic [REG_ADDR_W-1:0]   mem_rd_q;
    wb_ctrl_t                wb_q;
    logic [REG_ADDR_W-1:0]   wb_rd_q;
    logic                    lu, kill_id, wb_rw_eff;
    fwd_sel_e                fwd_a, fwd_b;

    assign id_bundle = '{alu_src:   id_alu_src,
                         mem2reg:   id_mem2reg,
                         reg_write: id_reg_write,
                         mem_read:  id_mem_read,
                         mem_write: id_mem_write,
                         aluop:     id_aluop,
                         branch:    id_branch,
                         jalr_mode: id_jalr_mode,
                         jal_mode:  id_jal_mode};

    // A load to x0 never produces a value worth waiting for.
    assign lu = ex_q.mem_read && (ex_rd_q != '0) &&
                ((id_uses_rs1 && (id_rs1 == ex_rd_q)) ||
                 (id_uses_rs2 && (id_rs2 == ex_rd_q)));

    // Both a redirect and a stall turn the ID slot into a bubble in EX.
    assign kill_id = ex_redirect || lu;

    always_comb begin
        ex_d     = id_bundle;
        ex_rd_d  = id_rd;
        ex_rs1_d = id_rs1;
        ex_rs2_d = id_rs2;
        if (kill_id) begin
            ex_d     = '0;
            ex_rd_d  = '0;
            ex_rs1_d = '0;
            ex_rs2_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ex_q     <= '0;
            ex_rd_q  <= '0;
            ex_rs1_q <= '0;
            ex_rs2_q <= '0;
            mem_q    <= '0;
            mem_rd_q <= '0;
            wb_q     <= '0;
            wb_rd_q  <= '0;
        end else begin
            ex_q     <= ex_d;
            ex_rd_q  <= ex_rd_d;
            ex_rs1_q <= ex_rs1_d;
            ex_rs2_q <= ex_rs2_d;
            mem_q    <= '{mem_read:  ex_q.mem_read,
                          mem_write: ex_q.mem_write,
                          mem2reg:   ex_q.mem2reg,
                          reg_write: ex_q.reg_write};
            mem_rd_q <= ex_rd_q;
            wb_q     <= '{mem2reg: mem_q.mem2reg, reg_write: mem_q.reg_write};
            wb_rd_q  <= mem_rd_q;
        end
    end

    // Writes to x0 are dropped here so neither the regfile nor the
    // forwarding logic ever sees x0 as a producer.
    assign wb_rw_eff = wb_q.reg_write && (wb_rd_q != '0);

    ctrl_fwd_unit #(.REG_ADDR_W(REG_ADDR_W)) u_fwd (
        .ex_rs1_i        (ex_rs1_q),
        .ex_rs2_i        (ex_rs2_q),
        .mem_reg_write_i (mem_q.reg_write),
        .mem_rd_i        (mem_rd_q),
        .wb_reg_write_i  (wb_rw_eff),
        .wb_rd_i         (wb_rd_q),
        .forward_a_o     (fwd_a),
        .forward_b_o     (fwd_b)
    );

    assign ex_ctrl       = {ex_q, 2'b00};
    assign ex_rd         = ex_rd_q;
    assign mem_mem_read  = mem_q.mem_read;
    assign mem_mem_write = mem_q.mem_write;
    assign mem_mem2reg   = mem_q.mem2reg;
    assign mem_reg_write = mem_q.reg_write;
    assign mem_rd        = mem_rd_q;
    assign wb_mem2reg    = wb_q.mem2reg;
    assign wb_reg_write  = wb_rw_eff;
    assign wb_rd         = wb_rd_q;
    assign forward_a     = fwd_a;
    assign forward_b     = fwd_b;

    // Redirect wins: fetch must move to the new target even if the
    // killed ID instruction would otherwise have stalled.
    assign pc_write   = ex_redirect || !lu;
    assign ifid_write = ex_redirect || !lu;
    assign ifid_flush = ex_redirect;

`ifdef CTRL_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (lu && !ex_redirect) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            if (ex_redirect)        flush_cnt_q <= flush_cnt_q + CNT_W'(1);
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_ctrl_pipe_stager.sv
// Scoreboard bench for ctrl_pipe_stager: a driver applies ID-stage
// instructions, predicts the DUT's outputs for that cycle from an
// instruction-level pipeline model and queues them; a monitor compares
// on the falling edge. Define CTRL_PERF_CNT_EN to also cover counters
// (instantiated with a 4-bit width so wrap-around is reached).
module tb_ctrl_pipe_stager;

    localparam int RW = 5;
    localparam int CW = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset;
    logic          id_alu_src, id_mem2reg, id_reg_write, id_mem_read, id_mem_write;
    logic          id_branch, id_jalr_mode, id_jal_mode;
    logic [1:0]    id_aluop;
    logic [RW-1:0] id_rs1, id_rs2, id_rd;
    logic          id_uses_rs1, id_uses_rs2, ex_redirect;
    logic [11:0]   ex_ctrl;
    logic [RW-1:0] ex_rd, mem_rd, wb_rd;
    logic          mem_mem_read, mem_mem_write, mem_mem2reg, mem_reg_write;
    logic          wb_mem2reg, wb_reg_write;
    logic [1:0]    forward_a, forward_b;
    logic          pc_write, ifid_write, ifid_flush;
`ifdef CTRL_PERF_CNT_EN
    logic [CW-1:0] stall_cnt, flush_cnt;
`endif

    ctrl_pipe_stager #(
        .REG_ADDR_W(RW)
`ifdef CTRL_PERF_CNT_EN
        , .CNT_W(CW)
`endif
    ) dut (
        .clk(clk), .reset(reset),
        .id_alu_src(id_alu_src), .id_mem2reg(id_mem2reg), .id_reg_write(id_reg_write),
        .id_mem_read(id_mem_read), .id_mem_write(id_mem_write), .id_branch(id_branch),
        .id_jalr_mode(id_jalr_mode), .id_jal_mode(id_jal_mode), .id_aluop(id_aluop),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .ex_redirect(ex_redirect),
        .ex_ctrl(ex_ctrl), .ex_rd(ex_rd),
        .mem_mem_read(mem_mem_read), .mem_mem_write(mem_mem_write),
        .mem_mem2reg(mem_mem2reg), .mem_reg_write(mem_reg_write), .mem_rd(mem_rd),
        .wb_mem2reg(wb_mem2reg), .wb_reg_write(wb_reg_write), .wb_rd(wb_rd),
        .forward_a(forward_a), .forward_b(forward_b),
        .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush)
`ifdef CTRL_PERF_CNT_EN
        , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
    );

    // One instruction as the decoder describes it.
    typedef struct {
        bit       alu_src, mem2reg, reg_write, mem_read, mem_write;
        bit [1:0] aluop;
        bit       branch, jalr, jal;
        bit [4:0] rd, rs1, rs2;
        bit       u1, u2;
    } instr_t;

    typedef struct {
        bit [11:0] ex_ctrl;
        bit [4:0]  ex_rd;
        bit [3:0]  memc;
        bit [4:0]  mem_rd;
        bit [1:0]  wbc;
        bit [4:0]  wb_rd;
        bit [1:0]  fa, fb;
        bit [2:0]  fetch;
        int        sc, fc;
    } exp_t;

    exp_t   q[$];
    int     n_chk = 0, n_pass = 0;
    instr_t m_ex, m_mem, m_wb;   // instructions currently occupying each stage
    int     m_stall = 0, m_flush = 0;

    function automatic instr_t nop();
        instr_t b;
        b = '{default: 0};
        return b;
    endfunction

    function automatic instr_t mk(bit rw, bit mr, bit [4:0] rd, bit [4:0] rs1,
                                  bit [4:0] rs2, bit u1, bit u2);
        instr_t i;
        i = nop();
        i.reg_write = rw; i.mem_read = mr; i.mem2reg = mr;
        i.rd = rd; i.rs1 = rs1; i.rs2 = rs2; i.u1 = u1; i.u2 = u2;
        return i;
    endfunction

    function automatic instr_t rnd();
        instr_t i;
        i.alu_src = 1'($urandom); i.mem2reg = 1'($urandom); i.reg_write = 1'($urandom);
        i.mem_read = ($urandom_range(0, 2) == 0); i.mem_write = 1'($urandom);
        i.aluop = 2'($urandom); i.branch = 1'($urandom);
        i.jalr = 1'($urandom); i.jal = 1'($urandom);
        i.rd = 5'($urandom_range(0, 7)); i.rs1 = 5'($urandom_range(0, 7));
        i.rs2 = 5'($urandom_range(0, 7));
        i.u1 = 1'($urandom); i.u2 = 1'($urandom);
        return i;
    endfunction

    // The youngest in-flight writer of rs supplies the operand.
    function automatic bit [1:0] fwd_of(bit [4:0] rs);
        if (m_mem.reg_write && m_mem.rd != 0 && m_mem.rd == rs) return 2'b10;
        if (m_wb.reg_write && m_wb.rd != 0 && m_wb.rd == rs)    return 2'b01;
        return 2'b00;
    endfunction

    task automatic chk(input string name, input longint act, input longint want);
        n_chk++;
        if (act == want) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, want, $time);
    endtask

    // Present one ID instruction for one cycle, predict, then advance the model.
    task automatic step(input instr_t id, input bit redir, input bit rst);
        exp_t e;
        bit   lu;
        reset = rst; ex_redirect = redir;
        id_alu_src = id.alu_src; id_mem2reg = id.mem2reg; id_reg_write = id.reg_write;
        id_mem_read = id.mem_read; id_mem_write = id.mem_write; id_aluop = id.aluop;
        id_branch = id.branch; id_jalr_mode = id.jalr; id_jal_mode = id.jal;
        id_rs1 = id.rs1; id_rs2 = id.rs2; id_rd = id.rd;
        id_uses_rs1 = id.u1; id_uses_rs2 = id.u2;

        lu = m_ex.mem_read && m_ex.rd != 0 &&
             ((id.u1 && id.rs1 == m_ex.rd) || (id.u2 && id.rs2 == m_ex.rd));
        e.ex_ctrl = {m_ex.alu_src, m_ex.mem2reg, m_ex.reg_write, m_ex.mem_read,
                     m_ex.mem_write, m_ex.aluop, m_ex.branch, m_ex.jalr, m_ex.jal, 2'b00};
        e.ex_rd   = m_ex.rd;
        e.memc    = {m_mem.mem_read, m_mem.mem_write, m_mem.mem2reg, m_mem.reg_write};
        e.mem_rd  = m_mem.rd;
        e.wbc     = {m_wb.mem2reg, m_wb.reg_write && m_wb.rd != 0};
        e.wb_rd   = m_wb.rd;
        e.fa      = fwd_of(m_ex.rs1);
        e.fb      = fwd_of(m_ex.rs2);
        e.fetch   = redir ? 3'b111 : (lu ? 3'b000 : 3'b110);
        e.sc      = m_stall;
        e.fc      = m_flush;
        q.push_back(e);

        @(posedge clk);
        if (rst) begin
            m_ex = nop(); m_mem = nop(); m_wb = nop();
            m_stall = 0; m_flush = 0;
        end else begin
            if (lu && !redir) m_stall = (m_stall + 1) % (1 << CW);
            if (redir)        m_flush = (m_flush + 1) % (1 << CW);
            m_wb  = m_mem;
            m_mem = m_ex;
            m_ex  = (redir || lu) ? nop() : id;
        end
        #1;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("ex_ctrl",  ex_ctrl, e.ex_ctrl);
                chk("ex_rd",    ex_rd, e.ex_rd);
                chk("mem_ctrl", {mem_mem_read, mem_mem_write, mem_mem2reg, mem_reg_write}, e.memc);
                chk("mem_rd",   mem_rd, e.mem_rd);
                chk("wb_ctrl",  {wb_mem2reg, wb_reg_write}, e.wbc);
                chk("wb_rd",    wb_rd, e.wb_rd);
                chk("forward_a", forward_a, e.fa);
                chk("forward_b", forward_b, e.fb);
                chk("fetch{pcw,ifw,flush}", {pc_write, ifid_write, ifid_flush}, e.fetch);
`ifdef CTRL_PERF_CNT_EN
                chk("stall_cnt", stall_cnt, e.sc);
                chk("flush_cnt", flush_cnt, e.fc);
`endif
            end
        end
    end

    initial begin : driver
        instr_t lw5, add, cur;
        bit     stalled;
        int     guard;
        lw5 = mk(1, 1, 5, 0, 0, 0, 0);
        add = mk(1, 0, 3, 5, 6, 1, 0);

        // Power-on reset with no predictions queued: state is unknown until it lands.
        reset = 1'b1; ex_redirect = 1'b0;
        cur = nop();
        id_alu_src = 0; id_mem2reg = 0; id_reg_write = 0; id_mem_read = 0;
        id_mem_write = 0; id_aluop = 0; id_branch = 0; id_jalr_mode = 0; id_jal_mode = 0;
        id_rs1 = 0; id_rs2 = 0; id_rd = 0; id_uses_rs1 = 0; id_uses_rs2 = 0;
        repeat (2) @(posedge clk);
        #1;
        m_ex = nop(); m_mem = nop(); m_wb = nop();

        // Reset state, then a reset that lands while a load sits in EX.
        step(nop(), 0, 0);
        step(lw5, 0, 0);
        step(nop(), 0, 1);
        step(nop(), 0, 0);

        // Load-use stall, then the held add enters EX fed from WB.
        step(lw5, 0, 0);
        step(add, 0, 0);
        step(add, 0, 0);
        step(nop(), 0, 0);
        step(nop(), 0, 0);

        // Load to x0 with a reader of x0: no stall.
        step(mk(1, 1, 0, 0, 0, 0, 0), 0, 0);
        step(mk(1, 0, 4, 0, 0, 1, 1), 0, 0);
        step(nop(), 0, 0);

        // Redirect coinciding with a load-use condition.
        step(lw5, 0, 0);
        step(add, 1, 0);
        step(nop(), 0, 0);

        // Two writers of x7 back to back: MEM copy must win.
        step(mk(1, 0, 7, 1, 0, 1, 0), 0, 0);
        step(mk(1, 0, 7, 2, 0, 1, 0), 0, 0);
        step(mk(1, 0, 9, 7, 7, 1, 1), 0, 0);
        step(nop(), 0, 0);
        step(nop(), 0, 0);

        // Sixteen isolated stalls from a clean reset: counter returns to 0.
        step(nop(), 0, 1);
        repeat (16) begin
            step(lw5, 0, 0);
            step(add, 0, 0);
        end
        step(nop(), 0, 0);
        step(nop(), 0, 0);

        // Random traffic; a stalled ID instruction is re-presented as fetch would.
        stalled = 0;
        repeat (500) begin
            bit redir, rst;
            if (!stalled) cur = rnd();
            redir = ($urandom_range(0, 9) == 0);
            rst   = ($urandom_range(0, 59) == 0);
            step(cur, redir, rst);
            stalled = !redir && !rst && (q[$].fetch == 3'b000);
        end
        step(nop(), 0, 0);

        guard = 0;
        while (q.size() > 0 && guard < 20) begin
            @(posedge clk);
            guard++;
        end
        chk("scoreboard_drained", q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
